// File: rtl/regfile_pkg.sv
// Shared constants and arbiter state encoding for the register-file write path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

    localparam int         RF_DATA_W   = 16;
    localparam int         RF_ADDR_W   = 3;
    localparam int         RF_DEPTH    = 8;
    localparam logic [2:0] RF_ZERO_REG = 3'd0;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first set bit of valid at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; any is low when no bit of valid is set.
module rr_priority_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               pos;
    logic [IDX_W-1:0] p;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        p     = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            p = IDX_W'(pos);
            if (!any && valid[p]) begin
                any      = 1'b1;
                grant[p] = 1'b1;
                idx      = p;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with lock sharing the register-file write port; ARB_GRANT_CNT_EN adds per-requester grant counters.
// Latency: transfer at posedge N drives rf_we/addr/data registered from posedge N until N+1.
// Backpressure: one-hot req_ready, at most one transfer per cycle; a locked owner excludes all others.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr_write,
    output logic [DATA_W-1:0]         rf_data_in,
    output logic                      arb_locked,
    output logic [OWN_W-1:0]          arb_owner
`ifdef ARB_GRANT_CNT_EN
   ,output logic [16*NUM_REQ-1:0]     grant_cnt
`endif
);

    arb_state_t         state, state_nxt;
    logic [OWN_W-1:0]   rr_ptr, rr_nxt;
    logic [OWN_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [OWN_W-1:0]   pick_idx;
    logic               pick_any;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_lock;

    function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] i);
        return (int'(i) >= NUM_REQ - 1) ? '0 : i + OWN_W'(1);
    endfunction

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (OWN_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        req_ready = '0;
        gnt_idx   = pick_idx;
        state_nxt = state;
        rr_nxt    = rr_ptr;

        case (state)
            ARB_IDLE: begin
                req_ready = pick_any ? pick_grant : '0;
                gnt_idx   = pick_idx;
            end
            ARB_LOCKED: begin
                req_ready[arb_owner] = req_valid[arb_owner];
                gnt_idx              = arb_owner;
            end
            default: ;
        endcase

        // No handshake may complete while reset is asserted.
        if (!rst) begin
            req_ready = '0;
        end

        xfer     = |(req_valid & req_ready);
        sel_addr = req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
        sel_data = req_data[int'(gnt_idx) * DATA_W +: DATA_W];
        sel_lock = req_lock[gnt_idx];

        case (state)
            ARB_IDLE: begin
                if (xfer) begin
                    if (sel_lock) begin
                        state_nxt = ARB_LOCKED;
                    end else begin
                        rr_nxt = wrap_inc(gnt_idx);
                    end
                end
            end
            ARB_LOCKED: begin
                // Owner dropping valid or clearing lock both release the port.
                if (!xfer || !sel_lock) begin
                    state_nxt = ARB_IDLE;
                    rr_nxt    = wrap_inc(arb_owner);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            arb_owner     <= '0;
            rf_we         <= 1'b0;
            rf_addr_write <= '0;
            rf_data_in    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            // r0 writes complete the handshake but never reach the register file.
            rf_we  <= xfer && (sel_addr != ADDR_W'(RF_ZERO_REG));
            if (xfer) begin
                rf_addr_write <= sel_addr;
                rf_data_in    <= sel_data;
                arb_owner     <= gnt_idx;
            end
        end
    end

    assign arb_locked = (state == ARB_LOCKED);

`ifdef ARB_GRANT_CNT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [15:0] cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt <= '0;
            end else if (req_valid[i] && req_ready[i] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a queue-free reference model.
// Three requesters are used so the round-robin wrap is not a trivial toggle.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_lock = '0;
    logic [AW*N-1:0] req_addr = '0;
    logic [DW*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_addr_write;
    logic [DW-1:0]   rf_data_in;
    logic            arb_locked;
    logic [OW-1:0]   arb_owner;
`ifdef ARB_GRANT_CNT_EN
    logic [16*N-1:0] grant_cnt;
`endif

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_lock      (req_lock),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_we         (rf_we),
        .rf_addr_write (rf_addr_write),
        .rf_data_in    (rf_data_in),
        .arb_locked    (arb_locked),
        .arb_owner     (arb_owner)
`ifdef ARB_GRANT_CNT_EN
       ,.grant_cnt     (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Register file committing on the falling edge.
    logic [DW-1:0] rf_mem [RF_DEPTH];
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] <= '0;
        end else if (rf_we === 1'b1) begin
            rf_mem[rf_addr_write] <= rf_data_in;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_locked;
    int            m_owner, m_ptr, m_addr, m_data;
    bit            m_we;
    int            m_cnt [N];
    logic [DW-1:0] exp_rf [RF_DEPTH];
    bit [N-1:0]    m_served;

    function automatic bit [N-1:0] model_ready();
        bit [N-1:0] r = '0;
        if (rst !== 1'b1) return r;
        if (m_locked) begin
            r[m_owner] = req_valid[m_owner];
            return r;
        end
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_update();
        bit [N-1:0] r;
        int g;
        m_served = '0;
        if (rst !== 1'b1) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            foreach (exp_rf[i]) exp_rf[i] = '0;
            return;
        end
        r = model_ready();
        if (r == '0) begin
            m_we = 0;
            if (m_locked) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
            return;
        end
        g = 0;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
        m_served[g] = 1'b1;
        m_addr  = int'(req_addr[g*AW +: AW]);
        m_data  = int'(req_data[g*DW +: DW]);
        m_owner = g;
        m_we    = (m_addr != 0);
        if (m_we) exp_rf[m_addr] = DW'(m_data);
        if (m_cnt[g] < 65535) m_cnt[g]++;
        if (req_lock[g]) m_locked = 1;
        else begin
            m_locked = 0;
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input int a, input int d);
        req_valid[i]           = v;
        req_lock[i]            = l;
        req_addr[i*AW +: AW]   = AW'(a);
        req_data[i*DW +: DW]   = DW'(d);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
        tick();
        tick();
        @(negedge clk); #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_checks++; if (rf_addr_write !== '0) begin n_fail++; $display("FAIL reset_rf_addr: got %0h want 0", rf_addr_write); end
        n_checks++; if (rf_data_in !== '0) begin n_fail++; $display("FAIL reset_rf_data: got %0h want 0", rf_data_in); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_checks++; if (arb_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", arb_locked); end
        n_checks++; if (arb_owner !== '0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", arb_owner); end
        // Valid during reset must not be granted.
        set_req(0, 1, 0, 5, 'h5a5a);
        @(negedge clk); #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready_forced: got %b want 0", req_ready); end
        set_req(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_single_write();
        rst = 1'b1;
        set_req(0, 1, 0, 3, 'h1234);
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b want 001", req_ready); end
        tick();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", rf_we); end
        n_checks++; if (rf_addr_write !== 3'd3) begin n_fail++; $display("FAIL single_addr: got %0d want 3", rf_addr_write); end
        n_checks++; if (rf_data_in !== 16'h1234) begin n_fail++; $display("FAIL single_data: got %0h want 1234", rf_data_in); end
        n_checks++; if (rf_mem[3] !== 16'h1234) begin n_fail++; $display("FAIL single_rf_r3: got %0h want 1234", rf_mem[3]); end
        tick();
    endtask

    task automatic test_round_robin();
        bit [N-1:0] exp;
        int prev = -1;
        set_req(0, 1, 0, 1, 'haaaa);
        set_req(1, 1, 0, 2, 'hbbbb);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            exp = model_ready();
            n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL rr_ready: cycle %0d got %b want %b", c, req_ready, exp); end
            if (prev >= 0) begin
                n_checks++; if (exp[prev] !== 1'b0) begin n_fail++; $display("FAIL rr_alternate: cycle %0d model regranted %0d", c, prev); end
                n_checks++; if (rf_addr_write !== AW'(prev + 1)) begin n_fail++; $display("FAIL rr_addr: cycle %0d got %0d want %0d", c, rf_addr_write, prev + 1); end
            end
            prev = exp[1] ? 1 : 0;
            tick();
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_lock_burst();
        int addrs [3] = '{5, 6, 2};
        bit locks [3] = '{1, 1, 0};
        int prev_addr = 4;
        set_req(1, 1, 1, 4, 'h4444);
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL lock_first_ready: got %b want 010", req_ready); end
        tick();
        set_req(0, 1, 0, 7, 'h7777);
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1, locks[k], addrs[k], 'h1000 + addrs[k]);
            @(negedge clk); #1;
            n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL lock_ready: step %0d got %b want 010", k, req_ready); end
            n_checks++; if (arb_locked !== 1'b1) begin n_fail++; $display("FAIL lock_flag: step %0d got %b want 1", k, arb_locked); end
            n_checks++; if (rf_addr_write !== AW'(prev_addr)) begin n_fail++; $display("FAIL lock_addr: step %0d got %0d want %0d", k, rf_addr_write, prev_addr); end
            prev_addr = addrs[k];
            tick();
        end
        set_req(1, 0, 0, 0, 0);
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL lock_release_ready: got %b want 001", req_ready); end
        n_checks++; if (arb_locked !== 1'b0) begin n_fail++; $display("FAIL lock_release_flag: got %b want 0", arb_locked); end
        n_checks++; if (rf_addr_write !== 3'd2) begin n_fail++; $display("FAIL lock_last_addr: got %0d want 2", rf_addr_write); end
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_r0_write();
        set_req(0, 1, 0, 0, 'hffff);
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL r0_ready: got %b want 001", req_ready); end
        tick();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %b want 0", rf_we); end
        n_checks++; if (rf_data_in !== 16'hffff) begin n_fail++; $display("FAIL r0_data: got %0h want ffff", rf_data_in); end
        n_checks++; if (rf_mem[0] !== 16'h0) begin n_fail++; $display("FAIL r0_rf: got %0h want 0", rf_mem[0]); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        set_req(0, 1, 1, 5, 'h5555);
        tick();
        set_req(0, 1, 1, 6, 'h6666);
        @(negedge clk); #1;
        n_checks++; if (arb_locked !== 1'b1) begin n_fail++; $display("FAIL midlock_locked: got %b want 1", arb_locked); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL midlock_ready_in_reset: got %b want 0", req_ready); end
        tick();
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        n_checks++; if (arb_locked !== 1'b0) begin n_fail++; $display("FAIL midlock_unlocked: got %b want 0", arb_locked); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midlock_we: got %b want 0", rf_we); end
        n_checks++; if (arb_owner !== '0) begin n_fail++; $display("FAIL midlock_owner: got %0d want 0", arb_owner); end
        tick();
`ifdef ARB_GRANT_CNT_EN
        set_req(0, 1, 0, 1, 'h0101);
        repeat (3) tick();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        n_checks++; if (grant_cnt[15:0] !== 16'd3) begin n_fail++; $display("FAIL cnt_req0: got %0d want 3", grant_cnt[15:0]); end
        n_checks++; if (grant_cnt[31:16] !== 16'd0) begin n_fail++; $display("FAIL cnt_req1: got %0d want 0", grant_cnt[31:16]); end
        tick();
`endif
    endtask

    task automatic test_random();
        bit [N-1:0] exp;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_served[i]) begin
                    set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                            int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
                end
            end
            rst = ($urandom_range(0, 63) != 0);
            @(negedge clk); #1;
            exp = model_ready();
            n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, req_ready, exp); end
            n_checks++; if (rf_we !== m_we) begin n_fail++; $display("FAIL rand_we: cycle %0d got %b want %b", c, rf_we, m_we); end
            n_checks++; if (rf_addr_write !== AW'(m_addr)) begin n_fail++; $display("FAIL rand_addr: cycle %0d got %0d want %0d", c, rf_addr_write, m_addr); end
            n_checks++; if (rf_data_in !== DW'(m_data)) begin n_fail++; $display("FAIL rand_data: cycle %0d got %0h want %0h", c, rf_data_in, m_data); end
            n_checks++; if (arb_locked !== m_locked) begin n_fail++; $display("FAIL rand_locked: cycle %0d got %b want %b", c, arb_locked, m_locked); end
            n_checks++; if (arb_owner !== OW'(m_owner)) begin n_fail++; $display("FAIL rand_owner: cycle %0d got %0d want %0d", c, arb_owner, m_owner); end
`ifdef ARB_GRANT_CNT_EN
            for (int i = 0; i < N; i++) begin
                n_checks++; if (grant_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin n_fail++; $display("FAIL rand_cnt%0d: cycle %0d got %0d want %0d", i, c, grant_cnt[i*16 +: 16], m_cnt[i]); end
            end
`endif
            tick();
        end
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        for (int i = 0; i < RF_DEPTH; i++) begin
            n_checks++; if (rf_mem[i] !== exp_rf[i]) begin n_fail++; $display("FAIL rand_rf_r%0d: got %0h want %0h", i, rf_mem[i], exp_rf[i]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_lock_burst();
        test_r0_write();
        test_reset_mid_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x16 register file between NUM_REQ write-back requesters (e.g. ALU result, load unit).
- Each requester uses a valid/ready handshake. Grants rotate round-robin. A requester can lock the port for back-to-back writes, such as a multi-word load.
- Outputs are registered on posedge clk, so the register file, which commits on negedge clk, samples stable values half a cycle later.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 16, write data width.
- ADDR_W, 3, register address width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 resets on posedge clk).
- req_valid  input  NUM_REQ  per-requester write request.
- req_lock  input  NUM_REQ  hold the grant after this transfer.
- req_addr  input  ADDR_W*NUM_REQ  flattened target addresses; requester i is at bits [i*ADDR_W +: ADDR_W].
- req_data  input  DATA_W*NUM_REQ  flattened write data; requester i is at bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot (or zero) grant; transfer = valid & ready.
- rf_we  output  1  register-file write enable (registered).
- rf_addr_write  output  ADDR_W  register-file write address (registered).
- rf_data_in  output  DATA_W  register-file write data (registered).
- arb_locked  output  1  high while in LOCKED state (registered).
- arb_owner  output  clog2(NUM_REQ)  last granted / locking requester (registered).

Behaviour:
- Reset (rst==0 at posedge):
  - rf_we=0, rf_addr_write=0, rf_data_in=0.
  - arb_locked=0, arb_owner=0, rr pointer=0, state=IDLE.
  - req_ready is forced to 0 while rst==0.
  - Reset mid-lock discards ownership. A transfer presented in the reset cycle is not performed.
- FSM states: IDLE (round-robin) and LOCKED (owner only).
- IDLE grant selection:
  - Combinational, from req_valid.
  - Search starts at rr pointer and wraps modulo NUM_REQ; the first valid requester gets req_ready.
  - No valid requester: req_ready=0 and rf_we<=0.
- LOCKED grant selection: req_ready[owner]=req_valid[owner]; all other ready bits are 0.
- On each posedge with a transfer by requester g:
  - rf_addr_write<=req_addr[g], rf_data_in<=req_data[g], arb_owner<=g.
  - rf_we<=1 only if req_addr[g]!=0.
  - Writes to r0 are accepted (handshake completes) but drop with rf_we<=0.
- Cycle with no transfer: rf_we<=0; rf_addr_write and rf_data_in hold their values.
- Latency: transfer at posedge N → rf_we high in cycle N..N+1 → register file commits at the negedge inside that cycle. One write per cycle maximum. Full throughput for a single continuous requester.
- Transitions:
  - IDLE, transfer g with req_lock[g]=1 → LOCKED, owner=g.
  - IDLE, transfer g with req_lock[g]=0 → stay IDLE, rr<=(g+1) mod NUM_REQ.
  - LOCKED, owner transfer with lock=1 → stay LOCKED.
  - LOCKED, owner transfer with lock=0 → IDLE, rr<=owner+1.
  - LOCKED, owner req_valid=0 → IDLE, rr<=owner+1, no write.
- Requester rules: once valid is asserted, addr, data and lock are held stable until the transfer. Withdrawal before ready is legal but discouraged. The arbiter never depends on lock when valid=0.
- Simultaneous requests: exactly one is granted per cycle; the others wait with ready=0. With NUM_REQ requesters continuously valid and unlocked, each is served once every NUM_REQ cycles.

Optional Feature:
- Macro ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt (16*NUM_REQ), one 16-bit saturating counter per requester.
  - Each counter increments on every transfer, including r0 drops, and stops at 16'hFFFF.
  - Counters clear on reset.
- Undefined: no port, no counters; all other behaviour is identical.

Decomposition:
- Package regfile_pkg holds:
  - constants RF_DATA_W=16, RF_ADDR_W=3, RF_DEPTH=8, RF_ZERO_REG=3'd0;
  - FSM state enum ARB_IDLE, ARB_LOCKED.
- One natural sub-module: rr_priority_pick, a combinational rotate-and-priority-encode taking valid vector and pointer and returning a one-hot grant and index.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, all valid=0 → rf_we=0, rf_addr_write=0, rf_data_in=0, req_ready=0, arb_locked=0.
- Single write: req0 valid, addr=3, data=16'h1234 → ready0=1, next cycle rf_we=1, addr=3, data=1234; register-file model r3=1234 after negedge.
- Round-robin: req0 and req1 continuously valid, lock=0, addrs 1 and 2 → grants alternate 0,1,0,1; rf_addr_write alternates 1,2.
- Lock burst: req1 lock=1 for 3 transfers (addr 4,5,6) while req0 valid → req0 ready=0 throughout; arb_locked=1; on the 4th transfer req1 has lock=0; req0 is granted next.
- r0 write: req0 addr=0, data=16'hFFFF → ready0=1, rf_we=0; register-file model r0 unchanged.
- Reset mid-lock: owner locked; rst=0 for one cycle → state IDLE, arb_locked=0, rf_we=0. Then with ARB_GRANT_CNT_EN: 3 transfers by req0 → grant_cnt[0]=3.
